pulse_width_checker: RTL and testbench
======================================

// Module: pulse_width_checker
// PURPOSE
//  Receive-side checker for the fixed-shape pulse protocol: a frame is exactly HIGH_LEN
//  high cycles followed by at least LOW_LEN low cycles. Monitors one synchronous line,
//  measures each high pulse and the gap after it, then flags a good frame or a classified
//  error. Sits at the far end of the pulse generator, in the same clock domain.
// PARAMETERS
//  HIGH_LEN  3  required high width, in cycles (>=1)
//  LOW_LEN   2  required minimum low gap after the high phase, in cycles (>=1)
//  CNT_W     8  width of the good-frame counter
//  LEN_W     4  width of the internal high/low counters (2**LEN_W > max(HIGH_LEN,LOW_LEN))
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  x_in       in   1      monitored pulse line, synchronous to clk
//  pulse_ok   out  1      one-cycle strobe: well-formed frame received
//  pulse_err  out  1      one-cycle strobe: malformed frame
//  err_code   out  2      valid only with pulse_err: 01 short, 10 long, 11 gap violation
//  ok_count   out  CNT_W  count of good frames, saturating
//  busy       out  1      high when state != IDLE
// BEHAVIOUR
//  - Reset (sync, rst=1 at the clk edge): state=IDLE, all counters 0, every output 0,
//    x_prev=1. A line that is already high at reset release is not treated as a rising edge.
//  - All outputs are registered. x_prev holds the previous sample of x_in.
//    A rising edge is x_in=1 with x_prev=0.
//  - Strobe timing: pulse_ok and pulse_err rise on the clk edge that samples the deciding
//    x_in value. They stay high for exactly one cycle. They are never high together.
//  - States:
//    IDLE: on a rising edge, set hcnt=1 and go to HIGH. Otherwise stay in IDLE.
//    HIGH, x_in=1: if hcnt==HIGH_LEN, raise err 10 and go to WAIT_LOW.
//       Otherwise hcnt++.
//    HIGH, x_in=0:
//       - hcnt<HIGH_LEN: raise err 01 and go to IDLE.
//       - hcnt==HIGH_LEN and LOW_LEN==1: raise ok and go to IDLE.
//       - hcnt==HIGH_LEN and LOW_LEN>1: set lcnt=1 and go to GAP.
//    GAP, x_in=0: lcnt++. When lcnt+1==LOW_LEN, raise ok and go to IDLE.
//    GAP, x_in=1: raise err 11. That high sample starts a new frame: hcnt=1, go to HIGH.
//    WAIT_LOW: stay until x_in=0, then go to IDLE. No strobes in this state.
//       A later rising edge starts a new frame.
//  - Latency: for a nominal frame, pulse_ok rises on the edge that samples the LOW_LEN-th
//    low cycle. Low cycles beyond LOW_LEN are idle time.
//  - ok_count increments on the same edge as pulse_ok. It holds at 2**CNT_W-1 (no wrap).
//  - err_code holds its last value between errors and resets to 00.
//    Check it only while pulse_err=1.
//  - Reset mid-frame wins over everything: it aborts the frame with no strobe.
//    The line must then go low and rise again before the next frame counts.
//  - Any undefined state encoding recovers to IDLE on the next edge.
// TESTING
//  1 Defaults. x_in: 0,1,1,1,0,0,0. -> pulse_ok one cycle, on the edge sampling the 2nd low.
//    ok_count 0->1. pulse_err stays 0.
//  2 x_in: 0,1,1,0,0. -> pulse_err on the edge sampling the 1st low, err_code=01.
//    ok_count unchanged.
//  3 x_in: 0,1,1,1,1,1,0. -> pulse_err, err_code=10, on the 4th high sample.
//    No further strobes until after the low. busy stays 1 until the low is sampled.
//  4 x_in: 0,1,1,1,0,1,1,1,0,0. -> err 11 on the 2nd frame's first high.
//    That frame then completes and gives pulse_ok. ok_count +1.
//  5 Hold x_in=1 through reset release, then 1,1,0. -> no strobes. Next clean frame -> pulse_ok.
//  6 CNT_W=2, five clean frames. -> ok_count 1,2,3,3,3. Also assert rst in mid-HIGH.
//    -> outputs 0 next cycle and no strobe.

Source files
------------

// File: rtl/pulse_width_checker.sv
// -----------------------------------------------------------------------------
// pulse_width_checker
//
// Receive-side checker for a fixed-shape pulse protocol. A frame is exactly
// HIGH_LEN high cycles followed by at least LOW_LEN low cycles. The block
// watches one line in the clk domain, measures each high pulse and the gap
// after it, and reports either a good frame or a classified error.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   x_in       in   1      monitored pulse line, synchronous to clk
//   pulse_ok   out  1      one-cycle strobe: well-formed frame received
//   pulse_err  out  1      one-cycle strobe: malformed frame
//   err_code   out  2      01 short, 10 long, 11 gap violation (valid with pulse_err)
//   ok_count   out  CNT_W  saturating count of good frames
//   busy       out  1      high while the checker is inside a frame
// -----------------------------------------------------------------------------
module pulse_width_checker #(
    parameter int HIGH_LEN = 3,
    parameter int LOW_LEN  = 2,
    parameter int CNT_W    = 8,
    parameter int LEN_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_in,
    output logic             pulse_ok,
    output logic             pulse_err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] ok_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HIGH     = 2'd1,
        S_GAP      = 2'd2,
        S_WAIT_LOW = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SHORT = 2'b01,
        ERR_LONG  = 2'b10,
        ERR_GAP   = 2'b11
    } err_e;

    localparam logic [LEN_W-1:0] HIGH_LEN_C = LEN_W'(HIGH_LEN);
    localparam logic [LEN_W-1:0] LOW_LEN_C  = LEN_W'(LOW_LEN);
    localparam logic [LEN_W-1:0] ONE_C      = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;

    state_e           state_q,     state_d;
    logic [LEN_W-1:0] hcnt_q,      hcnt_d;
    logic [LEN_W-1:0] lcnt_q,      lcnt_d;
    logic             x_prev_q,    x_prev_d;
    logic             pulse_ok_q,  pulse_ok_d;
    logic             pulse_err_q, pulse_err_d;
    err_e             err_code_q,  err_code_d;
    logic [CNT_W-1:0] ok_count_q,  ok_count_d;
    logic             busy_q,      busy_d;

    logic rise;
    logic ok_event;

    assign rise = x_in & ~x_prev_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; otherwise synthesis would infer a latch.
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        lcnt_d      = lcnt_q;
        x_prev_d    = x_in;
        pulse_err_d = 1'b0;
        err_code_d  = err_code_q;
        ok_event    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    hcnt_d  = ONE_C;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (x_in) begin
                    if (hcnt_q == HIGH_LEN_C) begin
                        pulse_err_d = 1'b1;
                        err_code_d  = ERR_LONG;
                        state_d     = S_WAIT_LOW;
                    end else begin
                        hcnt_d = hcnt_q + ONE_C;
                    end
                end else if (hcnt_q < HIGH_LEN_C) begin
                    pulse_err_d = 1'b1;
                    err_code_d  = ERR_SHORT;
                    state_d     = S_IDLE;
                end else if (LOW_LEN == 1) begin
                    ok_event = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    lcnt_d  = ONE_C;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (x_in) begin
                    // The offending high sample is also the first high of the
                    // next frame, so measurement restarts immediately.
                    pulse_err_d = 1'b1;
                    err_code_d  = ERR_GAP;
                    hcnt_d      = ONE_C;
                    state_d     = S_HIGH;
                end else begin
                    lcnt_d = lcnt_q + ONE_C;
                    if (lcnt_q + ONE_C == LOW_LEN_C) begin
                        ok_event = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_WAIT_LOW: begin
                if (!x_in) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pulse_ok_d = ok_event;
        ok_count_d = (ok_event && ok_count_q != CNT_MAX_C) ? ok_count_q + 1'b1 : ok_count_q;
        busy_d     = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            // Preset high so a line already high at reset release is not
            // mistaken for a rising edge.
            x_prev_q    <= 1'b1;
            pulse_ok_q  <= 1'b0;
            pulse_err_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            ok_count_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            lcnt_q      <= lcnt_d;
            x_prev_q    <= x_prev_d;
            pulse_ok_q  <= pulse_ok_d;
            pulse_err_q <= pulse_err_d;
            err_code_q  <= err_code_d;
            ok_count_q  <= ok_count_d;
            busy_q      <= busy_d;
        end
    end

    assign pulse_ok  = pulse_ok_q;
    assign pulse_err = pulse_err_q;
    assign err_code  = err_code_q;
    assign ok_count  = ok_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_width_checker.sv
// -----------------------------------------------------------------------------
// tb_pulse_width_checker
//
// Directed bench for pulse_width_checker. Two instances share the same
// stimulus: one with default parameters and one with a 2-bit good-frame
// counter to exercise saturation. Expected values are hand-derived per step.
// -----------------------------------------------------------------------------
module tb_pulse_width_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x_in = 1'b0;

    logic       pulse_ok,  pulse_ok_c2;
    logic       pulse_err, pulse_err_c2;
    logic [1:0] err_code,  err_code_c2;
    logic [7:0] ok_count;
    logic [1:0] ok_count_c2;
    logic       busy,      busy_c2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_width_checker u_dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .pulse_ok  (pulse_ok),
        .pulse_err (pulse_err),
        .err_code  (err_code),
        .ok_count  (ok_count),
        .busy      (busy)
    );

    pulse_width_checker #(.CNT_W(2)) u_dut_c2 (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .pulse_ok  (pulse_ok_c2),
        .pulse_err (pulse_err_c2),
        .err_code  (err_code_c2),
        .ok_count  (ok_count_c2),
        .busy      (busy_c2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one sample, clock it in, then check the registered outputs.
    task automatic step(input string tag, input logic x, input logic eok,
                        input logic eerr, input logic [1:0] ecode, input logic ebusy);
        x_in = x;
        @(posedge clk);
        #1;
        check({tag, ".ok"},    pulse_ok,     eok);
        check({tag, ".ok_c2"}, pulse_ok_c2,  eok);
        check({tag, ".err"},   pulse_err,    eerr);
        check({tag, ".busy"},  busy,         ebusy);
        if (eerr) check({tag, ".code"}, err_code, ecode);
    endtask

    task automatic do_reset(input logic x);
        x_in = x;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        check("rst.ok",    pulse_ok,    1'b0);
        check("rst.err",   pulse_err,   1'b0);
        check("rst.code",  err_code,    2'b00);
        check("rst.cnt",   ok_count,    8'd0);
        check("rst.cnt2",  ok_count_c2, 2'd0);
        check("rst.busy",  busy,        1'b0);
        rst = 1'b0;
    endtask

    // Nominal frame 0,1,1,1,0,0 then the expected counter values.
    task automatic clean_frame(input string tag, input int ecnt, input int ecnt2);
        step({tag, ".l0"}, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step({tag, ".h1"}, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step({tag, ".h2"}, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step({tag, ".h3"}, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step({tag, ".g1"}, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        step({tag, ".g2"}, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        check({tag, ".cnt"},  ok_count,    ecnt);
        check({tag, ".cnt2"}, ok_count_c2, ecnt2);
    endtask

    initial begin
        // 1: nominal frame, strobe on the second low sample
        do_reset(1'b0);
        clean_frame("t1", 1, 1);
        step("t1.idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);

        // 2: short pulse
        step("t2.l0", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t2.h1", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t2.h2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t2.l1", 1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
        step("t2.l2", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("t2.cnt", ok_count, 8'd1);

        // 3: long pulse, then silent until the line drops
        step("t3.l0", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t3.h1", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t3.h2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t3.h3", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t3.h4", 1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
        step("t3.h5", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t3.l1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("t3.cnt", ok_count, 8'd1);

        // 4: gap violation; the offending high starts a frame that completes
        step("t4.l0",  1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t4.h1",  1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.h2",  1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.h3",  1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.g1",  1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.bh1", 1'b1, 1'b0, 1'b1, 2'b11, 1'b1);
        step("t4.bh2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.bh3", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.bg1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t4.bg2", 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        check("t4.cnt",  ok_count,    8'd2);
        check("t4.code", err_code,    2'b11);

        // 5: line high through reset release is not a rising edge
        do_reset(1'b1);
        step("t5.h1", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t5.h2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t5.l1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        clean_frame("t5.f", 1, 1);

        // 6: saturation of the 2-bit counter, then reset in mid-HIGH
        do_reset(1'b0);
        clean_frame("t6.f1", 1, 1);
        clean_frame("t6.f2", 2, 2);
        clean_frame("t6.f3", 3, 3);
        clean_frame("t6.f4", 4, 3);
        clean_frame("t6.f5", 5, 3);
        step("t6.l0", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t6.h1", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        step("t6.h2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
        do_reset(1'b1);
        step("t6.r1", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t6.r2", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        step("t6.r3", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("t6.rcnt", ok_count, 8'd0);
        clean_frame("t6.f6", 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
